// File: rtl/dmem_arbiter_ctrl.sv
// Round-robin arbiter and beat sequencer sharing a byte-wide data memory between the CPU and the
// loader; each 32-bit word access becomes four big-endian byte beats followed by a one-cycle ack.
module dmem_arbiter_ctrl #(
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_err_o,

  input  logic              ldr_req_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [31:0]       ldr_wdata_i,
  output logic              ldr_ack_o,
  output logic [31:0]       ldr_rdata_o,
  output logic              ldr_err_o,

  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [ADDR_W:0] LastAddr = (ADDR_W+1)'(MEM_DEPTH - 1);

  state_e            state_q, state_d;
  logic              last_ldr_q, last_ldr_d;  // 1: loader held the most recent grant
  logic              sel_ldr_q, sel_ldr_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;

  logic              grant_cpu, grant_ldr;
  logic [ADDR_W-1:0] req_addr, req_base;
  logic [ADDR_W:0]   req_last;
  logic              req_oor;
  logic [7:0]        wdata_byte;
  logic              done;
  logic [31:0]       word_out;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{cpu_addr_i[1:0], ldr_addr_i[1:0]};

  always_comb begin
    grant_cpu = 1'b0;
    grant_ldr = 1'b0;
    if (cpu_req_i && ldr_req_i) begin
      grant_cpu = last_ldr_q;
      grant_ldr = !last_ldr_q;
    end else begin
      grant_cpu = cpu_req_i;
      grant_ldr = ldr_req_i;
    end
  end

  assign req_addr = grant_ldr ? ldr_addr_i : cpu_addr_i;
  assign req_base = {req_addr[ADDR_W-1:2], 2'b00};
  // Extra carry bit so a base near the top of the address space cannot wrap into range.
  assign req_last = {1'b0, req_base} + (ADDR_W+1)'(3);
  assign req_oor  = req_last > LastAddr;

  always_comb begin
    state_d    = state_q;
    last_ldr_d = last_ldr_q;
    sel_ldr_d  = sel_ldr_q;
    we_d       = we_q;
    err_d      = err_q;
    beat_d     = beat_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    unique case (state_q)
      StIdle: begin
        if (grant_cpu || grant_ldr) begin
          sel_ldr_d  = grant_ldr;
          last_ldr_d = grant_ldr;
          we_d       = grant_ldr ? ldr_we_i : cpu_we_i;
          wdata_d    = grant_ldr ? ldr_wdata_i : cpu_wdata_i;
          base_d     = req_base;
          err_d      = req_oor;
          beat_d     = 2'd0;
          rbuf_d     = 32'h0;
          state_d    = req_oor ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (!we_q) begin
          unique case (beat_q)
            2'd0: rbuf_d[31:24] = mem_rdata_i;
            2'd1: rbuf_d[23:16] = mem_rdata_i;
            2'd2: rbuf_d[15:8]  = mem_rdata_i;
            2'd3: rbuf_d[7:0]   = mem_rdata_i;
            default: ;
          endcase
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      last_ldr_q <= 1'b1;
      sel_ldr_q  <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      beat_q     <= 2'd0;
      base_q     <= '0;
      wdata_q    <= 32'h0;
      rbuf_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_ldr_q <= last_ldr_d;
      sel_ldr_q  <= sel_ldr_d;
      we_q       <= we_d;
      err_q      <= err_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
    end
  end

  always_comb begin
    wdata_byte = 8'h00;
    unique case (beat_q)
      2'd0: wdata_byte = wdata_q[31:24];
      2'd1: wdata_byte = wdata_q[23:16];
      2'd2: wdata_byte = wdata_q[15:8];
      2'd3: wdata_byte = wdata_q[7:0];
      default: ;
    endcase
  end

  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
    if (state_q == StAccess) begin
      mem_addr_o  = base_q + ADDR_W'(beat_q);
      mem_write_o = we_q;
      mem_read_o  = !we_q;
      if (we_q) begin
        mem_wdata_o = wdata_byte;
      end
    end
  end

  assign done     = (state_q == StDone);
  assign word_out = (!we_q && !err_q) ? rbuf_q : 32'h0;

  assign cpu_ack_o   = done && !sel_ldr_q;
  assign cpu_rdata_o = cpu_ack_o ? word_out : 32'h0;
  assign cpu_err_o   = cpu_ack_o && err_q;

  assign ldr_ack_o   = done && sel_ldr_q;
  assign ldr_rdata_o = ldr_ack_o ? word_out : 32'h0;
  assign ldr_err_o   = ldr_ack_o && err_q;

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Randomised scoreboard bench for dmem_arbiter_ctrl: a word-level memory model predicts every ack
// while a byte-wide memory attached to the DUT holds what the beats actually wrote.
module tb_dmem_arbiter_ctrl;

  localparam int unsigned Depth = 32;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata, cpu_rdata;
  logic          ldr_req, ldr_we, ldr_ack, ldr_err;
  logic [AW-1:0] ldr_addr;
  logic [31:0]   ldr_wdata, ldr_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter_ctrl #(.MEM_DEPTH(Depth), .ADDR_W(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_ack_o   (cpu_ack),
    .cpu_rdata_o (cpu_rdata),
    .cpu_err_o   (cpu_err),
    .ldr_req_i   (ldr_req),
    .ldr_we_i    (ldr_we),
    .ldr_addr_i  (ldr_addr),
    .ldr_wdata_i (ldr_wdata),
    .ldr_ack_o   (ldr_ack),
    .ldr_rdata_o (ldr_rdata),
    .ldr_err_o   (ldr_err),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  logic [7:0] phys [Depth];  // memory the DUT drives
  logic [7:0] refm [Depth];  // reference word-level image

  assign mem_rdata = (mem_addr < Depth) ? phys[mem_addr[4:0]] : 8'h00;

  always @(posedge clk) begin
    if (mem_write && mem_addr < Depth) phys[mem_addr[4:0]] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;  // -1: latency not checked
  } exp_t;

  exp_t cpu_q[$];
  exp_t ldr_q[$];
  int   ack_order[$];
  int   comps = 0;
  int   fails = 0;
  int   cyc = 0;
  int   strobes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_ack(input bit who, input logic [31:0] rd, input logic er);
    exp_t e;
    bit   empty;
    ack_order.push_back(int'(who));
    empty = who ? (ldr_q.size() == 0) : (cpu_q.size() == 0);
    comps++;
    if (empty) begin
      fails++;
      $display("FAIL %s_ack_unexpected: ack seen with rdata=%h err=%0b, required no ack",
               who ? "ldr" : "cpu", rd, er);
      return;
    end
    if (who) e = ldr_q.pop_front();
    else     e = cpu_q.pop_front();
    comps++;
    if (rd !== e.rdata || er !== e.err) begin
      fails++;
      $display("FAIL %s_resp: rdata=%h err=%0b, required rdata=%h err=%0b",
               who ? "ldr" : "cpu", rd, er, e.rdata, e.err);
    end
    if (e.cyc >= 0) begin
      comps++;
      if (cyc != e.cyc) begin
        fails++;
        $display("FAIL %s_latency: ack at cycle %0d, required cycle %0d",
                 who ? "ldr" : "cpu", cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      strobes++;
      comps++;
      if ((mem_read && mem_write) || mem_addr >= Depth) begin
        fails++;
        $display("FAIL strobe: read=%0b write=%0b addr=%0d, required one strobe below %0d",
                 mem_read, mem_write, mem_addr, Depth);
      end
    end
    if (cpu_ack && ldr_ack) begin
      fails++;
      $display("FAIL dual_ack: cpu_ack=1 ldr_ack=1, required at most one");
    end
    if (cpu_ack) check_ack(1'b0, cpu_rdata, cpu_err);
    if (ldr_ack) check_ack(1'b1, ldr_rdata, ldr_err);
    comps++;
    if ((!cpu_ack && (cpu_rdata != 32'h0 || cpu_err)) ||
        (!ldr_ack && (ldr_rdata != 32'h0 || ldr_err))) begin
      fails++;
      $display("FAIL idle_resp: cpu=%h/%0b ldr=%h/%0b outside ack, required 0",
               cpu_rdata, cpu_err, ldr_rdata, ldr_err);
    end
  end

  // Predicts the response from the word-level model, then runs one requester handshake.
  task automatic issue(input bit who, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit chk);
    exp_t   e;
    longint base;
    bit     got;
    int     s0;
    base    = longint'(addr) & ~longint'(3);
    e.err   = (base + 3) > (longint'(Depth) - 1);
    e.rdata = 32'h0;
    if (!e.err) begin
      for (int k = 0; k < 4; k++) begin
        if (we) refm[int'(base) + k] = wd[31-8*k -: 8];
        else    e.rdata[31-8*k -: 8] = refm[int'(base) + k];
      end
    end
    e.cyc = chk ? (cyc + 1 + (e.err ? 0 : 4)) : -1;
    if (who) ldr_q.push_back(e);
    else     cpu_q.push_back(e);
    s0 = strobes;
    if (who) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    @(posedge clk); #1;
    if (chk) begin
      if (who) begin
        ldr_we = 1'($urandom); ldr_addr = $urandom; ldr_wdata = $urandom;
      end else begin
        cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      end
    end
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (who ? ldr_ack : cpu_ack) begin
        got = 1'b1;
        break;
      end
    end
    comps++;
    if (!got) begin
      fails++;
      $display("FAIL %s_timeout: no ack within 60 cycles, required an ack", who ? "ldr" : "cpu");
    end
    @(posedge clk); #1;
    if (who) ldr_req = 1'b0;
    else     cpu_req = 1'b0;
    if (chk) begin
      comps++;
      if ((strobes - s0) != (e.err ? 0 : 4)) begin
        fails++;
        $display("FAIL %s_beats: %0d strobes, required %0d", who ? "ldr" : "cpu",
                 strobes - s0, e.err ? 0 : 4);
      end
    end
  endtask

  task automatic check_quiet(input string name);
    comps++;
    if ({cpu_ack, cpu_rdata, cpu_err, ldr_ack, ldr_rdata, ldr_err,
         mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL %s: ack=%0b/%0b rd=%0b wr=%0b addr=%h wdata=%h, required all 0",
               name, cpu_ack, ldr_ack, mem_read, mem_write, mem_addr, mem_wdata);
    end
  endtask

  task automatic check_no_strobes(input string name);
    int s0;
    s0 = strobes;
    repeat (3) @(posedge clk);
    #1;
    comps++;
    if (strobes != s0) begin
      fails++;
      $display("FAIL %s: %0d strobes with no requests, required 0", name, strobes - s0);
    end
  endtask

  initial begin
    int exp_order[6] = '{0, 1, 0, 1, 0, 1};
    for (int k = 0; k < int'(Depth); k++) begin
      phys[k] = 8'($urandom);
      refm[k] = phys[k];
    end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_quiet("reset_outputs");
    @(negedge clk) rst = 1'b1;
    check_no_strobes("post_reset_idle");

    // Both requesters present from reset: CPU wins first, then strict alternation.
    fork
      begin
        issue(1'b0, 1'b1, 32'd8, 32'h11223344, 1'b0);
        issue(1'b0, 1'b0, 32'd9, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 32'd12, $urandom, 1'b0);
      end
      begin
        issue(1'b1, 1'b1, 32'd0, 32'hA5A5A5A5, 1'b0);
        issue(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
        issue(1'b1, 1'b1, 32'd20, $urandom, 1'b0);
      end
    join
    for (int i = 0; i < 6; i++) begin
      int got_who;
      got_who = (i < ack_order.size()) ? ack_order[i] : -1;
      comps++;
      if (got_who != exp_order[i]) begin
        fails++;
        $display("FAIL grant_order[%0d]: requester %0d, required %0d", i, got_who, exp_order[i]);
      end
    end

    issue(1'b0, 1'b1, 32'd8, 32'h11223344, 1'b1);
    issue(1'b0, 1'b0, 32'd9, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 32'd30, 32'h0, 1'b1);
    issue(1'b1, 1'b1, 32'd28, 32'hCAFEF00D, 1'b1);

    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom), 1'($urandom), 32'($urandom_range(0, 39)), $urandom, 1'b1);
    end

    // Reset in the middle of beat 2 of a CPU write: beats 0 and 1 have already landed.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd16; cpu_wdata = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #3;
    comps++;
    if (!(mem_write && mem_addr == 32'd18 && mem_wdata == 8'hBE)) begin
      fails++;
      $display("FAIL beat2_write: wr=%0b addr=%0d data=%h, required wr=1 addr=18 data=be",
               mem_write, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    cpu_req = 1'b0;
    #1 check_quiet("async_reset_outputs");
    repeat (2) @(posedge clk);
    #1 check_quiet("held_reset_outputs");
    @(negedge clk) rst = 1'b1;
    refm[16] = 8'hDE;
    refm[17] = 8'hAD;
    check_no_strobes("post_abort_idle");
    issue(1'b0, 1'b0, 32'd16, 32'h0, 1'b1);

    for (int k = 0; k < int'(Depth); k++) begin
      comps++;
      if (phys[k] !== refm[k]) begin
        fails++;
        $display("FAIL mem[%0d]: %h, required %h", k, phys[k], refm[k]);
      end
    end
    comps++;
    if (cpu_q.size() != 0 || ldr_q.size() != 0) begin
      fails++;
      $display("FAIL pending_acks: %0d cpu / %0d ldr outstanding, required 0",
               cpu_q.size(), ldr_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
    $finish;
  end

endmodule
